// File: rtl/decrypt_writer.sv
// decrypt_writer: RC4 keystream generator (PRGA) over a pre-shuffled S RAM.
// It XORs MSG_LEN bytes of an encrypted ROM with the keystream and writes the
// result to an output RAM, then holds done high until reset.
//
// Ports
//   clk          sole clock, posedge
//   reset        synchronous active-high, aborts all activity
//   start        level, S shuffle complete; sampled only in IDLE
//   address_s    S RAM address       data_s    S RAM write data
//   wren_s       S RAM write enable  q_s       S RAM read data
//   address_rom  ROM address         q_rom     encrypted byte
//   address_ram2 output RAM address  data_ram2 decrypted byte
//   wren_ram2    output RAM write enable
//   done         all MSG_LEN bytes written
//
// Every memory output is a register loaded by the state that owns it, so it
// shows up on the cycle after that state and is cleared by the reset edge.
module decrypt_writer #(
    parameter int unsigned MSG_LEN   = 32,
    parameter int unsigned READ_WAIT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [7:0] address_s,
    output logic [7:0] data_s,
    output logic       wren_s,
    input  logic [7:0] q_s,
    output logic [4:0] address_rom,
    input  logic [7:0] q_rom,
    output logic [4:0] address_ram2,
    output logic [7:0] data_ram2,
    output logic       wren_ram2,
    output logic       done
);

    localparam int unsigned      CNT_W   = $clog2(READ_WAIT + 2);
    // RD_SI/RD_SJ see their address one cycle earlier than RD_F issues its own
    localparam logic [CNT_W-1:0] LAST_RD = CNT_W'(READ_WAIT - 1);
    localparam logic [CNT_W-1:0] LAST_F  = CNT_W'(READ_WAIT);
    localparam logic [5:0]       LAST_K  = 6'(MSG_LEN - 1);

    typedef enum logic [3:0] {
        IDLE, INC_I, RD_SI, CALC_J, RD_SJ, WR_SI, WR_SJ, RD_F, WR_OUT, NEXT_K, DONE
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [7:0]       r_i, r_j, r_si, r_sj, r_f, r_rom;
    logic [5:0]       r_k;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_address_s, r_data_s, r_data_ram2;
    logic [4:0]       r_address_rom, r_address_ram2;
    logic             r_wren_s, r_wren_ram2, r_done;

    logic [7:0]       w_i_nxt, w_j_nxt, w_si_nxt, w_sj_nxt, w_f_nxt, w_rom_nxt;
    logic [5:0]       w_k_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [7:0]       w_address_s_nxt, w_data_s_nxt, w_data_ram2_nxt;
    logic [4:0]       w_address_rom_nxt, w_address_ram2_nxt;
    logic             w_wren_s_nxt, w_wren_ram2_nxt, w_done_nxt;
    logic [7:0]       w_sum;

    assign w_sum = r_si + r_sj;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic; start is only looked at in IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = INC_I;
            INC_I:   w_state_nxt = RD_SI;
            RD_SI:   if (r_cnt == LAST_RD) w_state_nxt = CALC_J;
            CALC_J:  w_state_nxt = RD_SJ;
            RD_SJ:   if (r_cnt == LAST_RD) w_state_nxt = WR_SI;
            WR_SI:   w_state_nxt = WR_SJ;
            WR_SJ:   w_state_nxt = RD_F;
            RD_F:    if (r_cnt == LAST_F) w_state_nxt = WR_OUT;
            WR_OUT:  w_state_nxt = NEXT_K;
            NEXT_K:  w_state_nxt = (r_k == LAST_K) ? DONE : INC_I;
            DONE:    w_state_nxt = DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath and output register next values
    always_comb begin
        w_i_nxt            = r_i;
        w_j_nxt            = r_j;
        w_k_nxt            = r_k;
        w_si_nxt           = r_si;
        w_sj_nxt           = r_sj;
        w_f_nxt            = r_f;
        w_rom_nxt          = r_rom;
        w_cnt_nxt          = '0;
        w_address_s_nxt    = r_address_s;
        w_data_s_nxt       = r_data_s;
        w_address_rom_nxt  = r_address_rom;
        w_address_ram2_nxt = r_address_ram2;
        w_data_ram2_nxt    = r_data_ram2;
        w_wren_s_nxt       = 1'b0;
        w_wren_ram2_nxt    = 1'b0;
        w_done_nxt         = r_done;
        case (r_state)
            IDLE: begin
                w_i_nxt = '0;
                w_j_nxt = '0;
                w_k_nxt = '0;
            end
            INC_I: begin
                w_i_nxt         = r_i + 8'd1;
                w_address_s_nxt = r_i + 8'd1;
            end
            RD_SI: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == LAST_RD) w_si_nxt = q_s;
            end
            CALC_J: begin
                w_j_nxt         = r_j + r_si;
                w_address_s_nxt = r_j + r_si;
            end
            RD_SJ: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == LAST_RD) w_sj_nxt = q_s;
            end
            WR_SI: begin
                w_address_s_nxt = r_i;
                w_data_s_nxt    = r_sj;
                w_wren_s_nxt    = 1'b1;
            end
            WR_SJ: begin
                w_address_s_nxt = r_j;
                w_data_s_nxt    = r_si;
                w_wren_s_nxt    = 1'b1;
            end
            RD_F: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                // Address issued on entry; the S[j] write lands before it is read
                if (r_cnt == '0) begin
                    w_address_s_nxt   = w_sum;
                    w_address_rom_nxt = r_k[4:0];
                end
                if (r_cnt == LAST_F) begin
                    w_f_nxt   = q_s;
                    w_rom_nxt = q_rom;
                end
            end
            WR_OUT: begin
                w_address_ram2_nxt = r_k[4:0];
                w_data_ram2_nxt    = r_f ^ r_rom;
                w_wren_ram2_nxt    = 1'b1;
            end
            NEXT_K: begin
                if (r_k != LAST_K) w_k_nxt = r_k + 6'd1;
            end
            DONE: begin
                w_done_nxt = 1'b1;
            end
            default: begin
                w_i_nxt = '0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_i            <= '0;
            r_j            <= '0;
            r_k            <= '0;
            r_si           <= '0;
            r_sj           <= '0;
            r_f            <= '0;
            r_rom          <= '0;
            r_cnt          <= '0;
            r_address_s    <= '0;
            r_data_s       <= '0;
            r_address_rom  <= '0;
            r_address_ram2 <= '0;
            r_data_ram2    <= '0;
            r_wren_s       <= 1'b0;
            r_wren_ram2    <= 1'b0;
            r_done         <= 1'b0;
        end else begin
            r_i            <= w_i_nxt;
            r_j            <= w_j_nxt;
            r_k            <= w_k_nxt;
            r_si           <= w_si_nxt;
            r_sj           <= w_sj_nxt;
            r_f            <= w_f_nxt;
            r_rom          <= w_rom_nxt;
            r_cnt          <= w_cnt_nxt;
            r_address_s    <= w_address_s_nxt;
            r_data_s       <= w_data_s_nxt;
            r_address_rom  <= w_address_rom_nxt;
            r_address_ram2 <= w_address_ram2_nxt;
            r_data_ram2    <= w_data_ram2_nxt;
            r_wren_s       <= w_wren_s_nxt;
            r_wren_ram2    <= w_wren_ram2_nxt;
            r_done         <= w_done_nxt;
        end
    end

    assign address_s    = r_address_s;
    assign data_s       = r_data_s;
    assign wren_s       = r_wren_s;
    assign address_rom  = r_address_rom;
    assign address_ram2 = r_address_ram2;
    assign data_ram2    = r_data_ram2;
    assign wren_ram2    = r_wren_ram2;
    assign done         = r_done;

endmodule

// File: tb/tb_decrypt_writer.sv
// Bench for decrypt_writer: models S RAM, ROM and output RAM as registered-read
// memories and compares against a plain RC4 PRGA reference.
module tb_decrypt_writer;

    localparam int unsigned MSG_LEN   = 32;
    localparam int unsigned READ_WAIT = 3;

    logic       clk = 1'b0;
    logic       reset, start;
    logic [7:0] address_s, data_s, q_s, q_rom, data_ram2;
    logic       wren_s, wren_ram2, done;
    logic [4:0] address_rom, address_ram2;

    always #5 clk = ~clk;

    decrypt_writer #(.MSG_LEN(MSG_LEN), .READ_WAIT(READ_WAIT)) dut (
        .clk(clk), .reset(reset), .start(start),
        .address_s(address_s), .data_s(data_s), .wren_s(wren_s), .q_s(q_s),
        .address_rom(address_rom), .q_rom(q_rom),
        .address_ram2(address_ram2), .data_ram2(data_ram2), .wren_ram2(wren_ram2),
        .done(done)
    );

    logic [7:0] s_mem [256];
    logic [7:0] s_init[256];
    logic [7:0] exp_s [256];
    logic [7:0] rom   [32];
    logic [7:0] ram2  [32];
    logic [7:0] exp_ram2[32];
    logic       load_en = 1'b0;
    int         wr2_count = 0;
    logic [4:0] first_wr2 = '0;
    logic       collide = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    // Memories: synchronous write, one-cycle registered read
    always @(posedge clk) begin
        if (load_en) begin
            for (int n = 0; n < 256; n++) s_mem[n] <= s_init[n];
            for (int n = 0; n < 32; n++)  ram2[n]  <= 8'hEE;
            wr2_count <= 0;
            collide   <= 1'b0;
        end else begin
            if (wren_s) s_mem[address_s] <= data_s;
            if (wren_ram2) begin
                ram2[address_ram2] <= data_ram2;
                if (wr2_count == 0) first_wr2 <= address_ram2;
                wr2_count <= wr2_count + 1;
            end
            if (wren_s && wren_ram2) collide <= 1'b1;
        end
        q_s   <= s_mem[address_s];
        q_rom <= rom[address_rom];
    end

    typedef struct {
        int         s_mode;
        logic [7:0] rom_val;
        logic [7:0] exp0, exp1, exp2;
    } vec_t;
    vec_t tbl[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({address_s, data_s, wren_s, address_rom, address_ram2, data_ram2, wren_ram2, done});
    endfunction

    // mode 0 identity, 1 S[1]=C8/S[C8]=50, 2 random permutation
    task automatic set_s(input int mode);
        logic [7:0] t;
        int r;
        for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
        if (mode == 1) begin
            s_init[1] = 8'hC8; s_init[8'hC8] = 8'h50; s_init[8'h50] = 8'h01;
        end else if (mode == 2) begin
            for (int n = 255; n > 0; n--) begin
                r = int'($urandom_range(n, 0));
                t = s_init[n]; s_init[n] = s_init[r]; s_init[r] = t;
            end
        end
    endtask

    // Reference RC4 PRGA, textbook swap form
    task automatic model_run();
        logic [7:0] s[256];
        logic [7:0] i, j, t;
        i = 0; j = 0;
        for (int n = 0; n < 256; n++) s[n] = s_init[n];
        for (int k = 0; k < int'(MSG_LEN); k++) begin
            i = i + 8'd1;
            j = j + s[i];
            t = s[i]; s[i] = s[j]; s[j] = t;
            t = s[i] + s[j];
            exp_ram2[k] = s[t] ^ rom[k];
        end
        for (int n = 0; n < 256; n++) exp_s[n] = s[n];
    endtask

    // Reset with start high (reset wins), load memories, return to idle
    task automatic prepare();
        model_run();
        reset = 1'b1; start = 1'b1; load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
        @(negedge clk);
        check("reset_prio_outputs", outs(), 64'd0);
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("idle_outputs", outs(), 64'd0);
    endtask

    task automatic wait_ram2(input logic [4:0] addr);
        int t = 0;
        while (!(wren_ram2 && address_ram2 == addr) && t < 3000) begin
            @(negedge clk); t++;
        end
        check("ram2_write_seen", 64'(wren_ram2 && address_ram2 == addr), 64'd1);
    endtask

    task automatic wait_wren_s();
        int t = 0;
        while (!wren_s && t < 500) begin
            @(negedge clk); t++;
        end
        check("s_write_seen", 64'(wren_s), 64'd1);
    endtask

    task automatic finish_run();
        int t = 0;
        int bad = 0;
        while (!done && t < 3000) begin
            @(negedge clk); t++;
        end
        check("done", 64'(done), 64'd1);
        check("ram2_write_count", 64'(wr2_count), 64'(MSG_LEN));
        repeat (5) @(negedge clk);
        check("done_held", 64'(done), 64'd1);
        check("no_write_after_done", 64'(wr2_count), 64'(MSG_LEN));
        check("no_write_collision", 64'(collide), 64'd0);
        for (int k = 0; k < int'(MSG_LEN); k++) check("ram2_byte", 64'(ram2[k]), 64'(exp_ram2[k]));
        for (int n = 0; n < 256; n++) if (s_mem[n] !== exp_s[n]) bad++;
        check("final_s_mismatches", 64'(bad), 64'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        for (int n = 0; n < 32; n++) rom[n] = 8'h00;

        tbl[0] = '{0, 8'h00, 8'h02, 8'h05, 8'h07};
        tbl[1] = '{0, 8'hFF, 8'hFD, 8'hFA, 8'hF8};
        tbl[2] = '{1, 8'h00, 8'h18, 8'hCC, 8'hD0};
        tbl[3] = '{0, 8'h5A, 8'h58, 8'h5F, 8'h5D};

        // Table of known-answer vectors
        for (int v = 0; v < 4; v++) begin
            set_s(tbl[v].s_mode);
            for (int n = 0; n < 32; n++) rom[n] = tbl[v].rom_val;
            prepare();
            start = 1'b1;
            finish_run();
            check("kat_byte0", 64'(ram2[0]), 64'(tbl[v].exp0));
            check("kat_byte1", 64'(ram2[1]), 64'(tbl[v].exp1));
            check("kat_byte2", 64'(ram2[2]), 64'(tbl[v].exp2));
        end

        // Intermediate S after k=2, identity S, ROM FF
        set_s(0);
        for (int n = 0; n < 32; n++) rom[n] = 8'hFF;
        prepare();
        start = 1'b1;
        wait_ram2(5'd2);
        check("s2_after_k2", 64'(s_mem[2]), 64'h03);
        check("s3_after_k2", 64'(s_mem[3]), 64'h05);
        check("s5_after_k2", 64'(s_mem[5]), 64'h02);
        start = 1'b0;
        finish_run();

        // j and f address wrap: S[1]=C8, S[C8]=50
        set_s(1);
        for (int n = 0; n < 32; n++) rom[n] = 8'h00;
        prepare();
        start = 1'b1;
        wait_wren_s();
        check("wr_si_addr", 64'(address_s), 64'h01);
        check("wr_si_data", 64'(data_s), 64'h50);
        @(negedge clk);
        check("wr_sj_addr_j", 64'(address_s), 64'hC8);
        check("wr_sj_data", 64'(data_s), 64'hC8);
        wait_ram2(5'd0);
        check("f_addr_wrap", 64'(address_s), 64'h18);
        check("rom_addr_k0", 64'(address_rom), 64'h00);
        check("ram2_data_k0", 64'(data_ram2), 64'h18);
        finish_run();

        // i == j on k=0, identity S
        set_s(0);
        prepare();
        start = 1'b1;
        wait_wren_s();
        check("ieqj_first_addr", 64'(address_s), 64'h01);
        check("ieqj_first_data", 64'(data_s), 64'h01);
        @(negedge clk);
        check("ieqj_second_wren", 64'(wren_s), 64'd1);
        check("ieqj_second_addr", 64'(address_s), 64'h01);
        check("ieqj_second_data", 64'(data_s), 64'h01);
        @(negedge clk);
        check("ieqj_s1", 64'(s_mem[1]), 64'h01);
        finish_run();

        // Reset during RD_SJ of k=5, then restart from k=0
        set_s(0);
        for (int n = 0; n < 32; n++) rom[n] = 8'($urandom);
        prepare();
        start = 1'b1;
        wait_ram2(5'd4);
        repeat (7) @(negedge clk);
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        check("abort_outputs", outs(), 64'd0);
        check("abort_ram2_count", 64'(wr2_count), 64'd5);
        prepare();
        start = 1'b1;
        finish_run();
        check("restart_first_addr", 64'(first_wr2), 64'd0);

        // start held low: nothing moves
        begin
            int bad = 0;
            prepare();
            start = 1'b0;
            repeat (100) begin
                @(negedge clk);
                if (outs() != 64'd0) bad++;
            end
            check("idle_100_cycles", 64'(bad), 64'd0);
            check("idle_no_ram2_write", 64'(wr2_count), 64'd0);
        end

        // Random S permutations and ROM contents
        for (int r = 0; r < 4; r++) begin
            set_s(2);
            for (int n = 0; n < 32; n++) rom[n] = 8'($urandom);
            prepare();
            start = 1'b1;
            finish_run();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decrypt_writer.md
DECRYPT_WRITER -- requirements
Module: decrypt_writer

Interface
REQ-001 SHALL have parameter MSG_LEN, default 32: number of message bytes decrypted (1..32).
REQ-002 SHALL have parameter READ_WAIT, default 3: wait-state cycles between a memory address update and sampling of its q.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high; aborts all activity.
REQ-005 SHALL have port start  input  1  level; S-array shuffle complete, decryption may begin.
REQ-006 SHALL have port address_s  output  8  S RAM address.
REQ-007 SHALL have port data_s  output  8  S RAM write data.
REQ-008 SHALL have port wren_s  output  1  S RAM write enable.
REQ-009 SHALL have port q_s  input  8  S RAM read data.
REQ-010 SHALL have port address_rom  output  5  encrypted-message ROM address.
REQ-011 SHALL have port q_rom  input  8  encrypted byte.
REQ-012 SHALL have port address_ram2  output  5  decrypted-output RAM address.
REQ-013 SHALL have port data_ram2  output  8  decrypted byte.
REQ-014 SHALL have port wren_ram2  output  1  decrypted RAM write enable.
REQ-015 SHALL have port done  output  1  all MSG_LEN bytes written; drives key-search start.

Function
REQ-016 SHALL implement RC4 PRGA: i=0, j=0; for k=0..MSG_LEN-1: i=i+1; si=S[i]; j=j+si; sj=S[j]; S[i]=sj; S[j]=si; f=S[si+sj]; RAM2[k]=f XOR ROM[k].
REQ-017 SHALL compute i, j and si+sj as 8-bit values, wrapping modulo 256; k is 6-bit internally, address_* use k[4:0].
REQ-018 SHALL use states IDLE, INC_I, RD_SI, CALC_J, RD_SJ, WR_SI, WR_SJ, RD_F, WR_OUT, NEXT_K, DONE.
REQ-019 IDLE: clears i, j, k; moves to INC_I when start=1, else stays.
REQ-020 INC_I: i<=i+1, address_s<=i+1; RD_SI waits READ_WAIT cycles then latches si from q_s.
REQ-021 CALC_J: j<=j+si, address_s<=j+si; RD_SJ waits READ_WAIT cycles then latches sj.
REQ-022 WR_SI: address_s=i, data_s=sj, wren_s=1 one cycle; WR_SJ: address_s=j, data_s=si, wren_s=1 one cycle.
REQ-023 RD_F: address_s<=si+sj and address_rom<=k[4:0] in same cycle; waits READ_WAIT cycles, latches f and q_rom.
REQ-024 WR_OUT: address_ram2=k[4:0], data_ram2=f XOR ROM byte, wren_ram2=1 exactly one cycle.
REQ-025 NEXT_K: if k==MSG_LEN-1 go DONE, else k<=k+1, go INC_I.
REQ-026 DONE: done=1 held, no memory writes, stays until reset.
REQ-027 wren_s and wren_ram2 SHALL never be high in the same cycle and SHALL be 0 outside WR_SI, WR_SJ, WR_OUT.
REQ-028 When i==j, both writes SHALL occur in order; final S[i]=si.
REQ-029 Deassertion of start after leaving IDLE SHALL be ignored; only reset aborts.

Reset
REQ-030 reset=1 at a clock edge SHALL force IDLE and clear i, j, k, si, sj, f, done, all addresses, data_s, data_ram2, wren_s, wren_ram2 to 0.
REQ-031 reset mid-operation (including during WR_*) SHALL suppress any write in the following cycle; a partially modified S is not restored.
REQ-032 reset has priority over start; with reset and start both high, state remains IDLE.

Verification
REQ-033 S[x]=x, ROM all 0x00, MSG_LEN=32 -> RAM2[0]=0x02, RAM2[1]=0x05, RAM2[2]=0x07; done=1 after byte 31.
REQ-034 Same S, ROM all 0xFF -> RAM2[0]=0xFD, RAM2[1]=0xFA; S[2]=0x03, S[3]=0x05, S[5]=0x02 at end of k=2.
REQ-035 S[1]=0xC8, S[0xC8]=0x50, else S[x]=x -> k=0 reads f from address 0x18 (wrap), j=0xC8.
REQ-036 i==j case (identity S, k=0, i=j=1) -> two writes to address 1, S[1]=0x01 afterwards.
REQ-037 reset pulsed during RD_SJ of k=5 -> next cycle all outputs 0, state IDLE; restart with start=1 rewrites RAM2 from k=0.
REQ-038 start held low 100 cycles -> no address change, no write, done=0.
